// File: rtl/cic_ctrl_pkg.sv
// rtl/cic_ctrl_pkg.sv - shared types and constants for the CIC decimator controller
package cic_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam int CIC_STAGES = 2;
    localparam int MIN_RATIO  = 2;

endpackage

// File: rtl/cic_phase_ctr.sv
// rtl/cic_phase_ctr.sv - loadable modulo-R phase counter with terminal-count flag
module cic_phase_ctr #(
    parameter int RATIO_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               restart,
    input  logic               enable,
    input  logic [RATIO_W-1:0] ratio,
    output logic               tc
);

    localparam logic [RATIO_W-1:0] ONE = RATIO_W'(1);

    logic [RATIO_W-1:0] ph;

    assign tc = (ph == (ratio - ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= '0;
        end else if (restart) begin
            ph <= '0;
        end else if (enable) begin
            ph <= tc ? '0 : ph + ONE;
        end
    end

endmodule

// File: rtl/cic_decim_ctrl.sv
// rtl/cic_decim_ctrl.sv - CIC decimator sequencing, settle masking and output handoff
module cic_decim_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int STAGES  = CIC_STAGES,
    parameter int RATIO_W = 4,
    parameter int DATA_W  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [RATIO_W-1:0] cfg_ratio,
    input  logic [DATA_W-1:0]  cic_data,
    output logic               integ_en,
    output logic               comb_en,
    output logic               dp_clr,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               overrun
);

    localparam int                 SC_W    = $clog2(STAGES + 1);
    localparam logic [SC_W-1:0]    SC_LAST = SC_W'(STAGES - 1);
    localparam logic [SC_W-1:0]    SC_ONE  = SC_W'(1);
    localparam logic [RATIO_W-1:0] MIN_R   = RATIO_W'(MIN_RATIO);

    state_t             state_q;
    state_t             state_d;
    logic [RATIO_W-1:0] ratio_q;
    logic [SC_W-1:0]    sc;
    logic               tc;
    logic               active;
    logic               capture;

    assign active   = (state_q != ST_IDLE);
    assign integ_en = active;
    assign comb_en  = active && tc;
    // A strobe coinciding with a reload belongs to the old configuration and is dropped.
    assign capture  = !cfg_load && (state_q == ST_RUN) && comb_en;

    cic_phase_ctr #(
        .RATIO_W (RATIO_W)
    ) u_phase (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (cfg_load),
        .enable  (active),
        .ratio   (ratio_q),
        .tc      (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cfg_load) begin
            state_d = (cfg_ratio >= MIN_R) ? ST_SETTLE : ST_IDLE;
        end else if ((state_q == ST_SETTLE) && comb_en && (sc == SC_LAST)) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ratio_q   <= '0;
            sc        <= '0;
            dp_clr    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            dp_clr <= cfg_load;
            if (cfg_load) begin
                ratio_q   <= cfg_ratio;
                sc        <= '0;
                out_valid <= 1'b0;
                overrun   <= 1'b0;
            end else begin
                if ((state_q == ST_SETTLE) && comb_en) begin
                    sc <= sc + SC_ONE;
                end
                if (capture) begin
                    out_data  <= cic_data;
                    out_valid <= 1'b1;
                    if (out_valid && !out_ready) begin
                        overrun <= 1'b1;
                    end
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb/tb_cic_decim_ctrl.sv - scoreboard bench for cic_decim_ctrl against a timing-rule model
module tb_cic_decim_ctrl;

    localparam int STAGES  = 2;
    localparam int RATIO_W = 4;
    localparam int DATA_W  = 5;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               cfg_load  = 1'b0;
    logic [RATIO_W-1:0] cfg_ratio = '0;
    logic [DATA_W-1:0]  cic_data  = '0;
    logic               out_ready = 1'b0;
    logic               integ_en;
    logic               comb_en;
    logic               dp_clr;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               overrun;

    always #5 clk = ~clk;

    cic_decim_ctrl #(
        .STAGES  (STAGES),
        .RATIO_W (RATIO_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_load  (cfg_load),
        .cfg_ratio (cfg_ratio),
        .cic_data  (cic_data),
        .integ_en  (integ_en),
        .comb_en   (comb_en),
        .dp_clr    (dp_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: strobes fall at k+R-1+jR after a load sampled at edge k;
    // strobe number n (1-based) is captured only when n > STAGES.
    logic [DATA_W-1:0] sb[$];
    int  cyc   = 0;
    int  m_k   = -1;
    int  m_r   = 0;
    bit  m_act = 1'b0;
    bit  m_valid = 1'b0;
    bit  m_ovr   = 1'b0;
    bit  s_strobe, s_cap, s_acc;

    function automatic bit exp_strobe(input int c);
        if (!m_act) return 1'b0;
        return ((c - m_k + 1) % m_r) == 0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_act   = 1'b0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_k     = -1;
            m_r     = 0;
            sb.delete();
        end else begin
            s_strobe = exp_strobe(cyc);
            s_cap    = s_strobe && (((cyc - m_k + 1) / m_r) > STAGES) && !cfg_load;
            s_acc    = m_valid && out_ready;
            if (cfg_load) begin
                m_k     = cyc + 1;
                m_r     = int'(cfg_ratio);
                m_act   = (m_r >= 2);
                m_valid = 1'b0;
                m_ovr   = 1'b0;
                sb.delete();
            end else if (s_cap) begin
                if (m_valid && !out_ready) begin
                    m_ovr = 1'b1;
                    if (sb.size() > 0) void'(sb.pop_back());
                end
                sb.push_back(cic_data);
                m_valid = 1'b1;
            end else if (s_acc) begin
                m_valid = 1'b0;
            end
        end
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                check("rst_integ_en", int'(integ_en), 0);
                check("rst_comb_en", int'(comb_en), 0);
                check("rst_dp_clr", int'(dp_clr), 0);
                check("rst_out_valid", int'(out_valid), 0);
                check("rst_overrun", int'(overrun), 0);
                check("rst_out_data", int'(out_data), 0);
            end else begin
                check("integ_en", int'(integ_en), int'(m_act));
                check("comb_en", int'(comb_en), int'(exp_strobe(cyc)));
                check("dp_clr", int'(dp_clr), int'(cyc == m_k));
                check("out_valid", int'(out_valid), int'(m_valid));
                check("overrun", int'(overrun), int'(m_ovr));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_empty cycle=%0d actual=accept expected=no_sample", cyc);
                    end else begin
                        check("out_data", int'(out_data), int'(sb.pop_front()));
                    end
                end
            end
        end
    end

    // mode 0: random data/ready, 1: incrementing data and ready, 2: incrementing data, not ready
    task automatic tick(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cfg_load = 1'b0;
            if (mode == 0) begin
                cic_data  = DATA_W'($urandom);
                out_ready = ($urandom_range(0, 9) < 7);
            end else begin
                cic_data  = cic_data + DATA_W'(1);
                out_ready = (mode == 1);
            end
        end
    endtask

    task automatic load(input int r, output int k);
        cfg_load  = 1'b1;
        cfg_ratio = RATIO_W'(r);
        k         = cyc + 1;
    endtask

    int kk;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(50, 0);

        tick(1, 1);
        load(4, kk);
        tick(40, 1);

        load(4, kk);
        tick(12 + 8, 2);
        tick(10, 1);
        load(6, kk);
        tick(30, 1);

        load(4, kk);
        tick(1, 1);
        while (cyc < kk + 15) tick(1, 1);
        load(8, kk);
        tick(40, 1);

        load(1, kk);
        tick(30, 0);

        load(5, kk);
        tick(3, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(20, 0);

        for (int i = 0; i < 2500; i++) begin
            tick(1, 0);
            if ($urandom_range(0, 149) == 0) load(int'($urandom_range(0, 15)), kk);
        end

        tick(30, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
